// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: debounces a press, walks a one-hot column scan, and emits
// the first hit in scan order as Code = 4*row + col with a one-cycle Valid pulse.
module hex_keypad_scanner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] Code,
  output logic       Valid
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [STW-1:0] ST_LAST = STW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
  localparam logic [1:0] ST_SCAN         = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  localparam logic [3:0] COL_ALL   = 4'b1111;
  localparam logic [3:0] COL_FIRST = 4'b0001;
  localparam logic [1:0] COL_LAST  = 2'd3;

  logic [3:0]     row_meta;
  logic [3:0]     row_s;
  logic [1:0]     state,   state_n;
  logic [DBW-1:0] db_cnt,  db_cnt_n;
  logic [DBW-1:0] rel_cnt, rel_cnt_n;
  logic [STW-1:0] dwell,   dwell_n;
  logic [1:0]     col_idx, col_idx_n;
  logic [3:0]     col_q,   col_n;
  logic [3:0]     code_q,  code_n;
  logic           valid_q, valid_n;

  logic           row_any;
  logic [1:0]     row_idx;

  assign row_any = |row_s;

  // Lowest asserted row wins within the column being scanned.
  always_comb begin
    row_idx = 2'd0;
    if (row_s[0])      row_idx = 2'd0;
    else if (row_s[1]) row_idx = 2'd1;
    else if (row_s[2]) row_idx = 2'd2;
    else if (row_s[3]) row_idx = 2'd3;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_meta <= 4'd0;
      row_s    <= 4'd0;
    end else begin
      row_meta <= Row;
      row_s    <= row_meta;
    end
  end

  always_comb begin
    state_n   = state;
    db_cnt_n  = db_cnt;
    rel_cnt_n = rel_cnt;
    dwell_n   = dwell;
    col_idx_n = col_idx;
    col_n     = col_q;
    code_n    = code_q;
    valid_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        col_n = COL_ALL;
        if (row_any) begin
          state_n  = ST_DEBOUNCE;
          db_cnt_n = '0;
        end
      end

      ST_DEBOUNCE: begin
        col_n = COL_ALL;
        if (!row_any) begin
          state_n = ST_IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_n   = ST_SCAN;
          col_idx_n = 2'd0;
          dwell_n   = '0;
          col_n     = COL_FIRST;
        end else begin
          db_cnt_n = db_cnt + 1'b1;
        end
      end

      ST_SCAN: begin
        // Row is only trusted on the last dwell cycle, once the synchronizer
        // has caught up with the column change.
        if (dwell != ST_LAST) begin
          dwell_n = dwell + 1'b1;
        end else if (row_any) begin
          code_n    = {row_idx, col_idx};
          valid_n   = 1'b1;
          col_n     = COL_ALL;
          state_n   = ST_WAIT_RELEASE;
          rel_cnt_n = '0;
        end else if (col_idx != COL_LAST) begin
          col_idx_n = col_idx + 1'b1;
          dwell_n   = '0;
          col_n     = {col_q[2:0], 1'b0};
        end else begin
          state_n = ST_IDLE;
          col_n   = COL_ALL;
        end
      end

      ST_WAIT_RELEASE: begin
        col_n = COL_ALL;
        if (row_any) begin
          rel_cnt_n = '0;
        end else if (rel_cnt == DB_LAST) begin
          state_n = ST_IDLE;
        end else begin
          rel_cnt_n = rel_cnt + 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        col_n   = COL_ALL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      db_cnt  <= '0;
      rel_cnt <= '0;
      dwell   <= '0;
      col_idx <= 2'd0;
      col_q   <= COL_ALL;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      db_cnt  <= db_cnt_n;
      rel_cnt <= rel_cnt_n;
      dwell   <= dwell_n;
      col_idx <= col_idx_n;
      col_q   <= col_n;
      code_q  <= code_n;
      valid_q <= valid_n;
    end
  end

  assign Col   = col_q;
  assign Code  = code_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: keypad model plus a timing/priority reference model
// derived from the press-to-Valid latency formula and scan-order priority rule.
module tb_hex_keypad_scanner;

  localparam int D = 4;
  localparam int S = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  Row;
  logic [3:0]  Col;
  logic [3:0]  Code;
  logic        Valid;
  logic [15:0] keys;

  int checks   = 0;
  int failures = 0;
  logic [3:0] code_model = 4'd0;

  hex_keypad_scanner #(.DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S)) dut (
    .clock (clock),
    .reset (reset),
    .Row   (Row),
    .Col   (Col),
    .Code  (Code),
    .Valid (Valid)
  );

  always #5 clock = ~clock;

  // Key 4r+c shorts Row[r] to Col[c].
  always_comb begin
    for (int r = 0; r < 4; r++) Row[r] = |(keys[4*r +: 4] & Col);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First hit in scan order: lowest column, then lowest row.
  function automatic int first_key(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[4*r + c]) return 4*r + c;
    return -1;
  endfunction

  function automatic int latency(input int c);
    return 3 + D + S*(c + 1);
  endfunction

  function automatic logic [3:0] exp_col(input int n, input int c);
    logic [3:0] one;
    one = 4'b0001;
    if (n < 3 + D || n >= latency(c)) return 4'b1111;
    return one << ((n - (3 + D)) / S);
  endfunction

  // Keys already applied just after "edge 0"; follows them for hold cycles.
  task automatic run_hold(input logic [15:0] k, input int hold, input int glitch_at);
    int fk;
    int c;
    int lat;
    fk  = first_key(k);
    c   = fk % 4;
    lat = latency(c);
    for (int n = 1; n <= hold; n++) begin
      @(negedge clock);
      chk("col", 32'(Col), 32'(exp_col(n, c)));
      chk("valid", 32'(Valid), 32'(n == lat));
      if (n == lat) code_model = fk[3:0];
      chk("code", 32'(Code), 32'(code_model));
      if (glitch_at != 0 && n == glitch_at) keys = 16'h0;
      else keys = k;
    end
  endtask

  task automatic idle_gap(input int gap);
    keys = 16'h0;
    for (int n = 1; n <= gap; n++) begin
      @(negedge clock);
      chk("gap_valid", 32'(Valid), 32'd0);
      chk("gap_col", 32'(Col), 32'hF);
      chk("gap_code", 32'(Code), 32'(code_model));
    end
  endtask

  task automatic press(input logic [15:0] k, input int hold, input int gap, input int glitch_at);
    keys = k;
    run_hold(k, hold, glitch_at);
    idle_gap(gap);
  endtask

  task automatic wait_col(input logic [3:0] target, input string tag);
    int budget;
    budget = 40;
    while (Col !== target && budget > 0) begin
      @(negedge clock);
      chk("scan_valid", 32'(Valid), 32'd0);
      budget--;
    end
    if (Col !== target) chk(tag, 32'(Col), 32'(target));
  endtask

  initial begin
    logic [15:0] k;
    int hold;
    int gap;

    keys  = 16'h0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_col", 32'(Col), 32'hF);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_code", 32'(Code), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Two-cycle bounce must be rejected.
    keys = 16'h0001;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clock);
      if (n == 2) keys = 16'h0;
      chk("bounce_col", 32'(Col), 32'hF);
      chk("bounce_valid", 32'(Valid), 32'd0);
      chk("bounce_code", 32'(Code), 32'd0);
    end

    press(16'h0001, 24, 12, 0);   // key 0
    press(16'h0800, 30, 12, 0);   // key B, column 3
    press(16'h0204, 30, 12, 0);   // keys 9 and 2 together
    press(16'h0020, 100, 10, 50); // key 5 with a hold glitch
    press(16'h0020, 40, 12, 0);   // key 5 again

    // Reset while column 2 is being scanned.
    keys = 16'h8000;
    wait_col(4'b0100, "reach_col2");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_col", 32'(Col), 32'hF);
    chk("midrst_valid", 32'(Valid), 32'd0);
    chk("midrst_code", 32'(Code), 32'd0);
    code_model = 4'd0;
    run_hold(16'h8000, 30, 0);
    idle_gap(12);

    // Key released before its column is reached: no Valid.
    keys = 16'h8000;
    wait_col(4'b0010, "reach_col1");
    keys = 16'h0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      chk("lost_valid", 32'(Valid), 32'd0);
      chk("lost_code", 32'(Code), 32'(code_model));
    end
    chk("lost_col", 32'(Col), 32'hF);

    for (int i = 0; i < 16; i++) begin
      k    = 16'($urandom_range(1, 16'hFFFF));
      hold = $urandom_range(latency(3) + 2, 50);
      gap  = $urandom_range(D + 6, 20);
      press(k, hold, gap, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
